// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg
// Shared definitions for the Wishbone-to-Hyperbus request bridge.
//   state_t         one-hot FSM encoding used by hyperbus_wb
//   WB_DATA_WIDTH   Wishbone data width in bits
//   WB_SEL_WIDTH    number of byte lanes
//   HALFWORD_SHIFT  byte address to halfword address shift
//   sel_to_mask     converts Wishbone byte enables into FIFO write mask
package hyperbus_pkg;

   localparam int WB_DATA_WIDTH  = 32;
   localparam int WB_SEL_WIDTH   = WB_DATA_WIDTH / 8;
   localparam int HALFWORD_SHIFT = 1;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_ISSUE = 5'b00010,
      ST_WAIT  = 5'b00100,
      ST_RESP  = 5'b01000,
      ST_DRAIN = 5'b10000
   } state_t;

   // The FIFO block masks bytes that are NOT to be written, the opposite
   // sense of Wishbone byte enables.
   function automatic logic [WB_SEL_WIDTH-1:0] sel_to_mask(input logic [WB_SEL_WIDTH-1:0] sel);
      return ~sel;
   endfunction

endpackage

// File: rtl/hyperbus_wb_timeout.sv
// hyperbus_wb_timeout
// Loadable saturating counter with a terminal flag, used to time out a
// request that never receives a completion.
//   clk       clock
//   rst       synchronous active-high reset
//   load      restarts the count at 1
//   enable    advances the count by one (saturating at all-ones)
//   terminal  high in the cycle whose count advance reaches LIMIT
module hyperbus_wb_timeout #(
   parameter int WIDTH = 11,
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic terminal
);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_d;

   // Next count: load restarts at 1, enable advances but never wraps.
   always_comb begin
      count_d = count;
      if (load) begin
         count_d = WIDTH'(1);
      end else if (enable && (count != '1)) begin
         count_d = count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count_d;
      end
   end

   // Flag looks at the value being written so the registered error that
   // follows lands in the same cycle the stored count reaches LIMIT.
   assign terminal = enable && (count_d >= WIDTH'(LIMIT));

endmodule

// File: rtl/hyperbus_wb.sv
// hyperbus_wb
// Wishbone B4 classic-cycle slave bridging a 32-bit bus onto the user-side
// request interface of the Hyperbus FIFO block. One transaction in flight.
//   clk, rst              user clock, synchronous active-high reset
//   wb_adr_i/dat_i/sel_i  Wishbone byte address, write data, byte enables
//   wb_we_i, wb_cyc_i, wb_stb_i  Wishbone direction, cycle, strobe
//   wb_dat_o              registered read data
//   wb_ack_o, wb_err_o    one-cycle acknowledge / error
//   rrq, wrq              one-cycle read / write request pulses
//   adr_o                 halfword address inside the window
//   tx_dat_o, tx_mask_o   latched write data and inverted byte mask
//   tx_ready              write completion pulse
//   rx_dat_i, rx_valid    read data and read completion pulse
module hyperbus_wb
   import hyperbus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WINDOW_BITS = 23,
   parameter int          TIMEOUT     = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WB_DATA_WIDTH-1:0] wb_adr_i,
   input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
   input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
   input  logic                     wb_we_i,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
   output logic                     wb_ack_o,
   output logic                     wb_err_o,
   output logic                     rrq,
   output logic                     wrq,
   output logic [WB_DATA_WIDTH-1:0] adr_o,
   output logic [WB_DATA_WIDTH-1:0] tx_dat_o,
   output logic [WB_SEL_WIDTH-1:0]  tx_mask_o,
   input  logic                     tx_ready,
   input  logic [WB_DATA_WIDTH-1:0] rx_dat_i,
   input  logic                     rx_valid
);

   localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT != 0);

   state_t state;
   state_t state_d;

   logic                     is_write;
   logic                     is_write_d;
   logic                     ack_d;
   logic                     err_d;
   logic                     rrq_d;
   logic                     wrq_d;
   logic [WB_DATA_WIDTH-1:0] dat_d;
   logic [WB_DATA_WIDTH-1:0] adr_d;
   logic [WB_DATA_WIDTH-1:0] txd_d;
   logic [WB_SEL_WIDTH-1:0]  mask_d;

   logic [WB_DATA_WIDTH-1:0] offset;
   logic                     in_window;
   logic                     new_cycle;
   logic                     rd_done;
   logic                     wr_done;
   logic                     completion;
   logic                     timeout_term;
   logic                     timeout_hit;

   assign offset    = wb_adr_i - BASE_ADDR;
   assign in_window = ((offset >> WINDOW_BITS) == '0);

   // A strobe still held during our own ack/err cycle is the tail of the
   // cycle just answered, not a new request.
   assign new_cycle = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

   // Only the completion matching the outstanding direction counts.
   assign rd_done    = ~is_write & rx_valid;
   assign wr_done    =  is_write & tx_ready;
   assign completion = rd_done | wr_done;

   hyperbus_wb_timeout #(
      .WIDTH (CNT_W),
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .load     (state == ST_ISSUE),
      .enable   (state == ST_WAIT),
      .terminal (timeout_term)
   );

   assign timeout_hit = TIMEOUT_EN && timeout_term;

   // Next-state and next-output logic. Every output is registered, so the
   // values computed here appear one cycle after the inputs that caused them.
   always_comb begin
      state_d    = state;
      is_write_d = is_write;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      rrq_d      = 1'b0;
      wrq_d      = 1'b0;
      dat_d      = wb_dat_o;
      adr_d      = adr_o;
      txd_d      = tx_dat_o;
      mask_d     = tx_mask_o;

      case (state)
         ST_IDLE: begin
            if (new_cycle) begin
               if (!in_window) begin
                  err_d = 1'b1;
               end else if (wb_we_i && (wb_sel_i == '0)) begin
                  ack_d = 1'b1;
               end else begin
                  adr_d      = offset >> HALFWORD_SHIFT;
                  txd_d      = wb_dat_i;
                  mask_d     = sel_to_mask(wb_sel_i);
                  is_write_d = wb_we_i;
                  rrq_d      = ~wb_we_i;
                  wrq_d      = wb_we_i;
                  state_d    = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            state_d = ST_WAIT;
         end

         // Completion beats abort and timeout; an abort beats a timeout.
         ST_WAIT: begin
            if (completion) begin
               if (rd_done) begin
                  dat_d = rx_dat_i;
               end
               if (wb_cyc_i) begin
                  ack_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (!wb_cyc_i) begin
               state_d = ST_DRAIN;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = ST_DRAIN;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         // The FIFO block cannot cancel, so its answer must be consumed
         // before another request may be issued.
         ST_DRAIN: begin
            if (completion) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         is_write  <= 1'b0;
         wb_ack_o  <= 1'b0;
         wb_err_o  <= 1'b0;
         rrq       <= 1'b0;
         wrq       <= 1'b0;
         wb_dat_o  <= '0;
         adr_o     <= '0;
         tx_dat_o  <= '0;
         tx_mask_o <= '1;
      end else begin
         state     <= state_d;
         is_write  <= is_write_d;
         wb_ack_o  <= ack_d;
         wb_err_o  <= err_d;
         rrq       <= rrq_d;
         wrq       <= wrq_d;
         wb_dat_o  <= dat_d;
         adr_o     <= adr_d;
         tx_dat_o  <= txd_d;
         tx_mask_o <= mask_d;
      end
   end

endmodule

// File: tb/tb_hyperbus_wb.sv
// tb_hyperbus_wb
// Self-checking bench for hyperbus_wb. Each transaction is turned into a
// timeline of expected output pulses (by cycle number) from the bridge's
// timing rules; a compare process checks the DUT against that timeline on
// every cycle, and a FIFO-side process replays scheduled completions.
module tb_hyperbus_wb;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          WBITS = 23;
   localparam int          TO    = 16;
   localparam int          MAXC  = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i  = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        rrq;
   logic        wrq;
   logic [31:0] adr_o;
   logic [31:0] tx_dat_o;
   logic [3:0]  tx_mask_o;
   logic        tx_ready = 1'b0;
   logic [31:0] rx_dat_i = '0;
   logic        rx_valid = 1'b0;

   int cyc       = 0;
   int checks    = 0;
   int errors    = 0;
   int free_edge = 0;

   // Expected timeline, indexed by the cycle following each clock edge.
   bit          exp_rrq   [MAXC];
   bit          exp_wrq   [MAXC];
   bit          exp_ack   [MAXC];
   bit          exp_err   [MAXC];
   bit          exp_rdack [MAXC];
   logic [31:0] exp_adr   [MAXC];
   logic [31:0] exp_txd   [MAXC];
   logic [31:0] exp_rdat  [MAXC];
   logic [3:0]  exp_mask  [MAXC];

   // Completion pulses to be sampled by the DUT at the given edge.
   bit          sched_rx   [MAXC];
   bit          sched_tx   [MAXC];
   logic [31:0] sched_rdat [MAXC];

   hyperbus_wb #(
      .BASE_ADDR   (BASE),
      .WINDOW_BITS (WBITS),
      .TIMEOUT     (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_sel_i  (wb_sel_i),
      .wb_we_i   (wb_we_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_o  (wb_ack_o),
      .wb_err_o  (wb_err_o),
      .rrq       (rrq),
      .wrq       (wrq),
      .adr_o     (adr_o),
      .tx_dat_o  (tx_dat_o),
      .tx_mask_o (tx_mask_o),
      .tx_ready  (tx_ready),
      .rx_dat_i  (rx_dat_i),
      .rx_valid  (rx_valid)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, actual, expected);
      end
   endtask

   // FIFO side: drive whatever completion is scheduled for the next edge.
   initial begin
      forever begin
         tick();
         if (cyc + 1 < MAXC) begin
            rx_valid = sched_rx[cyc + 1];
            tx_ready = sched_tx[cyc + 1];
            rx_dat_i = sched_rx[cyc + 1] ? sched_rdat[cyc + 1] : $urandom;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (cyc < MAXC) begin
            checkOutput("rrq", 32'(rrq), 32'(exp_rrq[cyc]));
            checkOutput("wrq", 32'(wrq), 32'(exp_wrq[cyc]));
            checkOutput("wb_ack_o", 32'(wb_ack_o), 32'(exp_ack[cyc]));
            checkOutput("wb_err_o", 32'(wb_err_o), 32'(exp_err[cyc]));
            if (exp_rrq[cyc] || exp_wrq[cyc]) begin
               checkOutput("adr_o", adr_o, exp_adr[cyc]);
               checkOutput("tx_dat_o", tx_dat_o, exp_txd[cyc]);
               checkOutput("tx_mask_o", 32'(tx_mask_o), 32'(exp_mask[cyc]));
            end
            if (exp_rdack[cyc]) begin
               checkOutput("wb_dat_o", wb_dat_o, exp_rdat[cyc]);
            end
         end
      end
   end

   // One master transaction. lat: edges after the request pulse at which
   // the FIFO completes. abort_at: edges after the request at which the
   // master is seen with cyc low (0 = never). stray: add an opposite-
   // direction completion while waiting.
   task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input int lat, input int abort_at,
                                input logic [31:0] rdat, input bit stray);
      logic [31:0] offset;
      int s;
      int c;
      int e;
      int drop;
      tick();
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      s        = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
      offset   = adr - BASE;
      if (offset >= (32'd1 << WBITS)) begin
         exp_err[s] = 1'b1;
         drop       = s;
         free_edge  = s + 2;
      end else if (we && (sel == 4'h0)) begin
         exp_ack[s] = 1'b1;
         drop       = s;
         free_edge  = s + 2;
      end else begin
         if (we) exp_wrq[s] = 1'b1;
         else    exp_rrq[s] = 1'b1;
         exp_adr[s]  = offset >> 1;
         exp_txd[s]  = dat;
         exp_mask[s] = ~sel;
         c = s + lat;
         if (we) begin
            sched_tx[c] = 1'b1;
         end else begin
            sched_rx[c]   = 1'b1;
            sched_rdat[c] = rdat;
         end
         if (stray && lat >= 3) begin
            e = s + $urandom_range(2, lat - 1);
            if (we) begin
               sched_rx[e]   = 1'b1;
               sched_rdat[e] = $urandom;
            end else begin
               sched_tx[e] = 1'b1;
            end
         end
         if (abort_at > 0 && abort_at <= TO && abort_at <= lat) begin
            drop      = s + abort_at - 1;
            free_edge = c + 1;
         end else if (lat <= TO) begin
            exp_ack[c]   = 1'b1;
            exp_rdack[c] = !we;
            exp_rdat[c]  = rdat;
            drop         = c;
            free_edge    = c + 2;
         end else begin
            exp_err[s + TO] = 1'b1;
            drop            = s + TO;
            free_edge       = c + 1;
         end
      end
      while (cyc < drop) tick();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   initial begin
      #((MAXC - 16) * 10);
      errors++;
      $display("[TB] FAIL watchdog: got timeout, expected completion before cycle %0d", MAXC - 16);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   int          kind;
   int          lat;
   int          s;
   bit          we;
   logic [31:0] adr;
   logic [3:0]  sel;

   initial begin
      // Reset values.
      repeat (3) tick();
      checkOutput("rst_ack", 32'(wb_ack_o), 32'h0);
      checkOutput("rst_err", 32'(wb_err_o), 32'h0);
      checkOutput("rst_rrq", 32'(rrq), 32'h0);
      checkOutput("rst_wrq", 32'(wrq), 32'h0);
      checkOutput("rst_dat_o", wb_dat_o, 32'h0);
      checkOutput("rst_adr_o", adr_o, 32'h0);
      checkOutput("rst_tx_dat", tx_dat_o, 32'h0);
      checkOutput("rst_tx_mask", 32'(tx_mask_o), 32'hF);
      rst = 1'b0;

      // Read 0x10, completion 5 cycles after rrq.
      applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'hF, 5, 0, 32'hDEADBEEF, 1'b0);
      checkOutput("dir_read_ack", 32'(wb_ack_o), 32'h1);
      checkOutput("dir_read_dat", wb_dat_o, 32'hDEADBEEF);
      checkOutput("dir_read_adr", adr_o, 32'h0000_0008);

      // Partial write.
      applyStimulus(1'b1, 32'h0000_0020, 32'h12345678, 4'b0011, 4, 0, 32'h0, 1'b0);
      checkOutput("dir_write_ack", 32'(wb_ack_o), 32'h1);
      checkOutput("dir_write_mask", 32'(tx_mask_o), 32'hC);
      checkOutput("dir_write_dat", tx_dat_o, 32'h12345678);

      // Zero-mask write and first out-of-window address.
      applyStimulus(1'b1, 32'h0000_0030, 32'h55AA55AA, 4'h0, 2, 0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0080_0000, 32'h0, 4'hF, 2, 0, 32'h0, 1'b0);

      // Timeout with late completion, then a stalled read.
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'hF, TO + 4, 0, 32'hCAFEF00D, 1'b0);
      applyStimulus(1'b0, 32'h0000_0044, 32'h0, 4'hF, 4, 0, 32'h0BADF00D, 1'b0);
      checkOutput("post_timeout_dat", wb_dat_o, 32'h0BADF00D);

      // Master abort two cycles after wrq, then a normal read.
      applyStimulus(1'b1, 32'h0000_0080, 32'hA5A5A5A5, 4'hF, 6, 2, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0000_0084, 32'h0, 4'hF, 3, 0, 32'h13579BDF, 1'b0);
      checkOutput("post_abort_dat", wb_dat_o, 32'h13579BDF);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         we   = 1'($urandom_range(0, 1));
         adr  = $urandom & 32'h007F_FFFF;
         sel  = 4'($urandom_range(1, 15));
         repeat ($urandom_range(0, 2)) tick();
         case (kind)
            0: applyStimulus(we, 32'h0080_0000 | $urandom, $urandom, sel, 2, 0, 32'h0, 1'b0);
            1: applyStimulus(1'b1, adr, $urandom, 4'h0, 2, 0, 32'h0, 1'b0);
            2: begin
               lat = $urandom_range(3, 20);
               applyStimulus(we, adr, $urandom, sel, lat, $urandom_range(2, (lat < TO) ? lat : TO),
                             $urandom, 1'b1);
            end
            3: applyStimulus(we, adr, $urandom, sel, $urandom_range(TO + 1, TO + 8), 0, $urandom, 1'b1);
            default: applyStimulus(we, adr, $urandom, sel, $urandom_range(2, TO), 0, $urandom, 1'b1);
         endcase
      end

      // Reset during WAIT; the orphaned completion arrives in IDLE.
      tick();
      s = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b0;
      wb_adr_i = 32'h0000_0100;
      wb_dat_i = 32'h0;
      wb_sel_i = 4'hF;
      exp_rrq[s]    = 1'b1;
      exp_adr[s]    = 32'h0000_0080;
      exp_txd[s]    = 32'h0;
      exp_mask[s]   = 4'h0;
      sched_rx[s + 8]   = 1'b1;
      sched_rdat[s + 8] = 32'hFEEDFACE;
      while (cyc < s + 2) tick();
      rst      = 1'b1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      tick();
      checkOutput("midrst_ack", 32'(wb_ack_o), 32'h0);
      checkOutput("midrst_rrq", 32'(rrq), 32'h0);
      checkOutput("midrst_adr", adr_o, 32'h0);
      checkOutput("midrst_mask", 32'(tx_mask_o), 32'hF);
      rst = 1'b0;
      free_edge = s + 10;
      while (cyc < s + 9) tick();
      checkOutput("stray_rx_dat", wb_dat_o, 32'h0);

      applyStimulus(1'b0, 32'h0000_0200, 32'h0, 4'hF, 3, 0, 32'h2468ACE0, 1'b0);
      checkOutput("final_read_dat", wb_dat_o, 32'h2468ACE0);

      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
